// File: rtl/ubx_nav_emitter.sv
// UBX transmitter: emits NAV-POSLLH then NAV-VELNED (or CFG ACK-ACK with
// UBX_ACK_EN) byte by byte to a UART with running Fletcher checksums.
// Ports: clk, rst (async high); send request; time_/lon/lat/ground_speed
// values latched per pair; busy; tx_data/tx_send to UART, tx_busy back;
// rx_data/rx_new from UART receiver (only used when UBX_ACK_EN is defined).
module ubx_nav_emitter (
  input  logic        clk,
  input  logic        rst,
  input  logic        send,
  input  logic [31:0] time_,
  input  logic [31:0] lon,
  input  logic [31:0] lat,
  input  logic [31:0] ground_speed,
  output logic        busy,
  output logic [7:0]  tx_data,
  output logic        tx_send,
  input  logic        tx_busy,
  input  logic [7:0]  rx_data,
  input  logic        rx_new
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SEND, S_GAP, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    F_POS, F_VEL, F_ACK
  } frame_t;

  state_t      state_q, state_d;
  frame_t      frame_q, frame_d;
  logic [5:0]  idx_q, idx_d;
  logic [7:0]  ck_a_q, ck_a_d;
  logic [7:0]  ck_b_q, ck_b_d;
  logic        send_pending_q, send_pending_d;
  logic [31:0] itow_q, itow_d;
  logic [31:0] lon_q, lon_d;
  logic [31:0] lat_q, lat_d;
  logic [31:0] gspd_q, gspd_d;
  logic [7:0]  tx_id_q, tx_id_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_send_q, tx_send_d;
  logic        busy_q, busy_d;

  logic        ack_pending;
  logic [7:0]  ack_id;
  logic        ack_take;
  logic        pend_clear;
  logic [5:0]  last_idx;
  logic [5:0]  ck_last;
  logic [7:0]  cur_byte;
  logic [5:0]  off;
  logic [7:0]  ck_a_n;

  assign ack_take = (state_q == S_IDLE) && ack_pending;

`ifdef UBX_ACK_EN
  typedef enum logic [1:0] {
    R_SYNC1, R_SYNC2, R_CLASS, R_ID
  } rstate_t;

  rstate_t    rstate_q, rstate_d;
  logic       ack_pending_q, ack_pending_d;
  logic [7:0] ack_id_q, ack_id_d;

  // A new CFG match wins over a take in the same cycle.
  always_comb begin
    rstate_d      = rstate_q;
    ack_pending_d = ack_pending_q & ~ack_take;
    ack_id_d      = ack_id_q;
    if (rx_new) begin
      unique case (rstate_q)
        R_SYNC1: rstate_d = (rx_data == 8'hB5) ? R_SYNC2 : R_SYNC1;
        R_SYNC2: begin
          if (rx_data == 8'h62)      rstate_d = R_CLASS;
          else if (rx_data == 8'hB5) rstate_d = R_SYNC2;
          else                       rstate_d = R_SYNC1;
        end
        R_CLASS: rstate_d = (rx_data == 8'h06) ? R_ID : R_SYNC1;
        R_ID: begin
          rstate_d      = R_SYNC1;
          ack_pending_d = 1'b1;
          ack_id_d      = rx_data;
        end
        default: rstate_d = R_SYNC1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rstate_q      <= R_SYNC1;
      ack_pending_q <= 1'b0;
      ack_id_q      <= 8'h00;
    end else begin
      rstate_q      <= rstate_d;
      ack_pending_q <= ack_pending_d;
      ack_id_q      <= ack_id_d;
    end
  end

  assign ack_pending = ack_pending_q;
  assign ack_id      = ack_id_q;
`else
  logic unused_rx;
  assign unused_rx   = ^{rx_data, rx_new};
  assign ack_pending = 1'b0;
  assign ack_id      = 8'h00;
`endif

  // ck_last is the last payload byte; the two bytes after it are CK_A/CK_B.
  always_comb begin
    unique case (frame_q)
      F_VEL:   begin last_idx = 6'd43; ck_last = 6'd41; end
      F_ACK:   begin last_idx = 6'd9;  ck_last = 6'd7;  end
      default: begin last_idx = 6'd35; ck_last = 6'd33; end
    endcase
  end

  // Word fields start at payload offsets that are multiples of 4,
  // so idx-6 gives the little-endian byte lane for all of them.
  assign off = idx_q - 6'd6;

  always_comb begin
    cur_byte = 8'h00;
    if (idx_q == last_idx) begin
      cur_byte = ck_b_q;
    end else if (idx_q == ck_last + 6'd1) begin
      cur_byte = ck_a_q;
    end else if (idx_q == 6'd0) begin
      cur_byte = 8'hB5;
    end else if (idx_q == 6'd1) begin
      cur_byte = 8'h62;
    end else begin
      unique case (frame_q)
        F_VEL: begin
          unique case (1'b1)
            idx_q == 6'd2:                 cur_byte = 8'h01;
            idx_q == 6'd3:                 cur_byte = 8'h12;
            idx_q == 6'd4:                 cur_byte = 8'h24;
            idx_q >= 6'd6 && idx_q <= 6'd9:
              cur_byte = itow_q[8*off[1:0] +: 8];
            idx_q >= 6'd26 && idx_q <= 6'd29:
              cur_byte = gspd_q[8*off[1:0] +: 8];
            default:                       cur_byte = 8'h00;
          endcase
        end
        F_ACK: begin
          unique case (1'b1)
            idx_q == 6'd2: cur_byte = 8'h05;
            idx_q == 6'd3: cur_byte = 8'h01;
            idx_q == 6'd4: cur_byte = 8'h02;
            idx_q == 6'd6: cur_byte = 8'h06;
            idx_q == 6'd7: cur_byte = tx_id_q;
            default:       cur_byte = 8'h00;
          endcase
        end
        default: begin
          unique case (1'b1)
            idx_q == 6'd2:                 cur_byte = 8'h01;
            idx_q == 6'd3:                 cur_byte = 8'h02;
            idx_q == 6'd4:                 cur_byte = 8'h1C;
            idx_q >= 6'd6 && idx_q <= 6'd9:
              cur_byte = itow_q[8*off[1:0] +: 8];
            idx_q >= 6'd10 && idx_q <= 6'd13:
              cur_byte = lon_q[8*off[1:0] +: 8];
            idx_q >= 6'd14 && idx_q <= 6'd17:
              cur_byte = lat_q[8*off[1:0] +: 8];
            default:                       cur_byte = 8'h00;
          endcase
        end
      endcase
    end
  end

  assign ck_a_n = ck_a_q + cur_byte;

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    idx_d      = idx_q;
    ck_a_d     = ck_a_q;
    ck_b_d     = ck_b_q;
    itow_d     = itow_q;
    lon_d      = lon_q;
    lat_d      = lat_q;
    gspd_d     = gspd_q;
    tx_id_d    = tx_id_q;
    tx_data_d  = tx_data_q;
    tx_send_d  = 1'b0;
    pend_clear = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ack_pending) begin
          frame_d = F_ACK;
          tx_id_d = ack_id;
          state_d = S_LOAD;
        end else if (send_pending_q) begin
          itow_d     = time_;
          lon_d      = lon;
          lat_d      = lat;
          gspd_d     = ground_speed;
          pend_clear = 1'b1;
          frame_d    = F_POS;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        idx_d   = 6'd0;
        ck_a_d  = 8'h00;
        ck_b_d  = 8'h00;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (!tx_busy) begin
          tx_send_d = 1'b1;
          tx_data_d = cur_byte;
          state_d   = S_GAP;
        end
      end
      S_GAP: begin
        if (idx_q >= 6'd2 && idx_q <= ck_last) begin
          ck_a_d = ck_a_n;
          ck_b_d = ck_b_q + ck_a_n;
        end
        idx_d   = idx_q + 6'd1;
        state_d = (idx_q == last_idx) ? S_DONE : S_SEND;
      end
      S_DONE: begin
        if (frame_q == F_POS) begin
          frame_d = F_VEL;
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A request landing on the consuming edge stays pending.
    send_pending_d = (send_pending_q & ~pend_clear) | send;
    busy_d         = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      frame_q        <= F_POS;
      idx_q          <= 6'd0;
      ck_a_q         <= 8'h00;
      ck_b_q         <= 8'h00;
      send_pending_q <= 1'b0;
      itow_q         <= 32'h0;
      lon_q          <= 32'h0;
      lat_q          <= 32'h0;
      gspd_q         <= 32'h0;
      tx_id_q        <= 8'h00;
      tx_data_q      <= 8'h00;
      tx_send_q      <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      frame_q        <= frame_d;
      idx_q          <= idx_d;
      ck_a_q         <= ck_a_d;
      ck_b_q         <= ck_b_d;
      send_pending_q <= send_pending_d;
      itow_q         <= itow_d;
      lon_q          <= lon_d;
      lat_q          <= lat_d;
      gspd_q         <= gspd_d;
      tx_id_q        <= tx_id_d;
      tx_data_q      <= tx_data_d;
      tx_send_q      <= tx_send_d;
      busy_q         <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign tx_data = tx_data_q;
  assign tx_send = tx_send_q;

endmodule
